led_string_rx: RTL

//  Decodes one WS2812-style single-wire LED stream back into 24-bit pixel words on clk_20.

---
 rtl/led_string_rx_pkg.sv | 16 +
 rtl/led_string_rx_sync_2ff.sv | 29 ++
 rtl/led_string_rx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/led_string_rx_pkg.sv
// Shared WS2812 timing constants (clk_20 cycles) and the receiver state type.
// The string transmitter uses the same constants so both ends agree on bit timing.
package led_string_rx_pkg;

  localparam int T0H    = 8;
  localparam int T1H    = 16;
  localparam int TBIT   = 25;
  localparam int TRESET = 1000;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } rx_state_e;

endpackage

// File: rtl/led_string_rx_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/led_string_rx.sv
// WS2812-style single-wire receiver: measures high pulse widths, rebuilds 24-bit
// pixel words and reports pixels, frame latches and line errors as 1-cycle strobes.
//
// state | meaning
// SYNC  | waiting for a full reset-length low before trusting the line
// LOW   | line low: bit gap, or latch once the low reaches T_RESET
// HIGH  | line high: measuring a data pulse
module led_string_rx
  import led_string_rx_pkg::*;
#(
  parameter int T_MIN_HIGH   = 3,
  parameter int T_THRESH     = (T0H + T1H) / 2,
  parameter int T_MAX_HIGH   = TBIT - 1,
  parameter int T_RESET      = TRESET,
  parameter int BITS_PER_LED = 24,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sdi,
  output logic [BITS_PER_LED-1:0] pixel_data,
  output logic                    pixel_valid,
  output logic                    frame_done,
  output logic [COUNT_WIDTH-1:0]  led_count,
  output logic                    err_glitch,
  output logic                    err_timing,
  output logic                    err_partial
);

  localparam int CNT_W = $clog2(T_RESET + 1);
  localparam int BIT_W = $clog2(BITS_PER_LED);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(T_RESET);
  localparam logic [CNT_W-1:0] CNT_LATCH = CNT_W'(T_RESET - 1);

  logic s;
  logic s_q, s_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rx_state_e state_q, state_d;
  logic [BITS_PER_LED-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bits_q, bits_d;
  logic [COUNT_WIDTH-1:0] pixels_q, pixels_d;
  logic [BITS_PER_LED-1:0] pixel_data_q, pixel_data_d;
  logic [COUNT_WIDTH-1:0] led_count_q, led_count_d;
  logic pixel_valid_q, pixel_valid_d;
  logic frame_done_q, frame_done_d;
  logic err_glitch_q, err_glitch_d;
  logic err_timing_q, err_timing_d;
  logic err_partial_q, err_partial_d;
  logic line_edge;
  logic latch;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sdi),
    .q     (s)
  );

  always_comb begin
    s_d    = s;
    rise_d = s & ~s_q;
    fall_d = ~s & s_q;

    // Edges are registered, so s_q is the line level aligned with rise_q/fall_q.
    line_edge = rise_q | fall_q;
    if (line_edge)              cnt_d = CNT_W'(1);
    else if (cnt_q != CNT_SAT)  cnt_d = cnt_q + CNT_W'(1);
    else                        cnt_d = cnt_q;

    // Fires only on the step into saturation, so each low period latches once.
    latch = ~s_q & ~line_edge & (cnt_q == CNT_LATCH);

    state_d       = state_q;
    shift_d       = shift_q;
    bits_d        = bits_q;
    pixels_d      = pixels_q;
    pixel_data_d  = pixel_data_q;
    led_count_d   = led_count_q;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    err_glitch_d  = 1'b0;
    err_timing_d  = 1'b0;
    err_partial_d = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if (latch) state_d = ST_LOW;
      end
      ST_LOW: begin
        if (rise_q) begin
          state_d = ST_HIGH;
        end else if (latch) begin
          err_partial_d = (bits_q != '0);
          if (pixels_q != '0) begin
            frame_done_d = 1'b1;
            led_count_d  = pixels_q;
          end
          bits_d   = '0;
          pixels_d = '0;
        end
      end
      ST_HIGH: begin
        if (cnt_q > CNT_W'(T_MAX_HIGH)) begin
          err_timing_d = 1'b1;
          bits_d       = '0;
          state_d      = ST_SYNC;
        end else if (fall_q) begin
          state_d = ST_LOW;
          if (cnt_q < CNT_W'(T_MIN_HIGH)) begin
            err_glitch_d = 1'b1;
          end else begin
            shift_d = {shift_q[BITS_PER_LED-2:0], (cnt_q >= CNT_W'(T_THRESH))};
            if (bits_q == BIT_W'(BITS_PER_LED - 1)) begin
              pixel_data_d  = shift_d;
              pixel_valid_d = 1'b1;
              bits_d        = '0;
              if (pixels_q != {COUNT_WIDTH{1'b1}}) pixels_d = pixels_q + COUNT_WIDTH'(1);
            end else begin
              bits_d = bits_q + BIT_W'(1);
            end
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q           <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      cnt_q         <= '0;
      state_q       <= ST_SYNC;
      shift_q       <= '0;
      bits_q        <= '0;
      pixels_q      <= '0;
      pixel_data_q  <= '0;
      led_count_q   <= '0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_glitch_q  <= 1'b0;
      err_timing_q  <= 1'b0;
      err_partial_q <= 1'b0;
    end else begin
      s_q           <= s_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      shift_q       <= shift_d;
      bits_q        <= bits_d;
      pixels_q      <= pixels_d;
      pixel_data_q  <= pixel_data_d;
      led_count_q   <= led_count_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q  <= frame_done_d;
      err_glitch_q  <= err_glitch_d;
      err_timing_q  <= err_timing_d;
      err_partial_q <= err_partial_d;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign frame_done  = frame_done_q;
  assign led_count   = led_count_q;
  assign err_glitch  = err_glitch_q;
  assign err_timing  = err_timing_q;
  assign err_partial = err_partial_q;

endmodule
